// File: rtl/pad_reader_pkg.sv
// rtl/pad_reader_pkg.sv - shared state encoding and button bit map for the serial pad reader
package pad_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } pad_state_e;

    localparam int PAD_BITS_DEF = 16;

    // Bit positions in a button word, in the order the pad shifts them out.
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

endpackage

// File: rtl/pad_reader_if.sv
// rtl/pad_reader_if.sv - bus-side control/status and pad-side serial lines of the pad reader
interface pad_reader_if
    import pad_reader_pkg::*;
#(
    parameter int PAD_BITS = PAD_BITS_DEF
);
    logic                start;
    logic                frame_tick;
    logic                auto_poll_en;
    logic                busy;
    logic                done;
    logic                pad_latch;
    logic                pad_clk;
    logic [1:0]          pad_data;
    logic [PAD_BITS-1:0] pad1_buttons;
    logic [PAD_BITS-1:0] pad2_buttons;

    modport slave (
        input  start, frame_tick, auto_poll_en, pad_data,
        output busy, done, pad_latch, pad_clk, pad1_buttons, pad2_buttons
    );

    modport master (
        output start, frame_tick, auto_poll_en, pad_data,
        input  busy, done, pad_latch, pad_clk, pad1_buttons, pad2_buttons
    );
endinterface

// File: rtl/pad_reader_input_sync.sv
// rtl/pad_reader_input_sync.sv - two-flop synchronizer for the two asynchronous pad data lines
module pad_input_sync (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] data_i,
    output logic [1:0] data_o
);
    logic [1:0] meta_q;
    logic [1:0] sync_q;

    // Resets to 1 so an idle/disconnected line reads as "not pressed".
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
        end
    end

    assign data_o = sync_q;
endmodule

// File: rtl/pad_reader.sv
// rtl/pad_reader.sv - SNES-style two-pad serial poller with frame-atomic button word update
module pad_reader
    import pad_reader_pkg::*;
#(
    parameter int CLK_DIV  = 64,
    parameter int PAD_BITS = PAD_BITS_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    pad_reader_if.slave  bus
);
    localparam int PH_W  = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(PAD_BITS);

    localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(PAD_BITS - 1);

    pad_state_e          state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [PAD_BITS-1:0] shift1_q, shift1_d;
    logic [PAD_BITS-1:0] shift2_q, shift2_d;
    logic [PAD_BITS-1:0] btn1_q, btn1_d;
    logic [PAD_BITS-1:0] btn2_q, btn2_d;
    logic                latch_q, latch_d;
    logic                pclk_q, pclk_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [1:0]          data_sync;
    logic                trig;

    pad_input_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .data_i (bus.pad_data),
        .data_o (data_sync)
    );

    assign trig = bus.start | (bus.frame_tick & bus.auto_poll_en);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shift1_d = shift1_q;
        shift2_d = shift2_q;
        btn1_d   = btn1_q;
        btn2_d   = btn2_q;

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                bit_d   = '0;
                if (trig) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    state_d = ST_HIGH;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_HIGH: begin
                // Sample at the end of the high half so the synchronizer has settled.
                if (phase_q == HALF_LAST) begin
                    shift1_d[bit_q] = ~data_sync[0];
                    shift2_d[bit_q] = ~data_sync[1];
                    state_d         = ST_LOW;
                    phase_d         = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_LOW: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_DONE;
                        btn1_d  = shift1_q;
                        btn2_d  = shift2_q;
                    end else begin
                        state_d = ST_HIGH;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, keeping the pad lines glitch-free.
        latch_d = (state_d == ST_LATCH);
        pclk_d  = (state_d != ST_LOW);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            shift1_q <= '0;
            shift2_q <= '0;
            btn1_q   <= '0;
            btn2_q   <= '0;
            latch_q  <= 1'b0;
            pclk_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shift1_q <= shift1_d;
            shift2_q <= shift2_d;
            btn1_q   <= btn1_d;
            btn2_q   <= btn2_d;
            latch_q  <= latch_d;
            pclk_q   <= pclk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.pad_latch    = latch_q;
    assign bus.pad_clk      = pclk_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pad1_buttons = btn1_q;
    assign bus.pad2_buttons = btn2_q;
endmodule

// File: tb/tb_pad_reader.sv
// tb/tb_pad_reader.sv - directed self-checking bench for pad_reader with two behavioural pads
module tb_pad_reader;
    logic clk = 1'b0;
    logic resetn;

    pad_reader_if #(.PAD_BITS(16)) pif ();

    pad_reader #(.CLK_DIV(4), .PAD_BITS(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (pif.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural pads: latch reloads bit 0, each rising pad clock advances one bit.
    logic [15:0] pat1 = 16'h0000;
    logic [15:0] pat2 = 16'h0000;
    int          idx  = 16;

    always @(posedge pif.pad_latch) idx = 0;
    always @(posedge pif.pad_clk) if (!pif.pad_latch) idx = idx + 1;

    assign pif.pad_data = (idx < 16) ? {~pat2[idx[3:0]], ~pat1[idx[3:0]]} : 2'b11;

    int          done_cyc, done_cnt, busy_cyc, latch_cyc, low_cyc, low_pulses;
    int          min_len, max_len, hold_bad;
    logic [15:0] b1_done, b2_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind: 0 = start pulse, 1 = frame_tick pulse, 2 = no trigger. Cycle 0 is the trigger cycle.
    task automatic run_poll(input int kind, input int cycles, input int extra_start, input int extra_tick);
        logic [15:0] h1, h2;
        int          cur;
        logic        prev_clk;
        h1 = pif.pad1_buttons;
        h2 = pif.pad2_buttons;
        done_cyc = -1; done_cnt = 0; busy_cyc = 0; latch_cyc = 0; low_cyc = 0;
        low_pulses = 0; min_len = 1000; max_len = 0; hold_bad = 0;
        b1_done = 16'h0; b2_done = 16'h0;
        cur = 0;
        prev_clk = 1'b1;
        @(negedge clk);
        pif.start      = (kind == 0);
        pif.frame_tick = (kind == 1);
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            pif.start      = (k == extra_start);
            pif.frame_tick = (k == extra_tick);
            if (pif.busy) busy_cyc++;
            if (pif.pad_latch) latch_cyc++;
            if (pif.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    b1_done  = pif.pad1_buttons;
                    b2_done  = pif.pad2_buttons;
                end
            end else if (done_cyc < 0 && (pif.pad1_buttons !== h1 || pif.pad2_buttons !== h2)) begin
                hold_bad++;
            end
            if (!pif.pad_clk) begin
                low_cyc++;
                cur++;
            end else if (!prev_clk) begin
                low_pulses++;
                if (cur < min_len) min_len = cur;
                if (cur > max_len) max_len = cur;
                cur = 0;
            end
            prev_clk = pif.pad_clk;
        end
    endtask

    initial begin
        int bad;
        pif.start        = 1'b0;
        pif.frame_tick   = 1'b0;
        pif.auto_poll_en = 1'b0;
        resetn           = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b1;

        run_poll(2, 200, -1, -1);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_latch", pif.pad_latch, 1'b0);
        check("rst_clk", pif.pad_clk, 1'b1);
        check("rst_busy", pif.busy, 1'b0);
        check("rst_b1", pif.pad1_buttons, 16'h0000);
        check("rst_b2", pif.pad2_buttons, 16'h0000);

        pat1 = 16'hA5C3; pat2 = 16'h0001;
        run_poll(0, 160, -1, -1);
        check("p1_done_cyc", done_cyc, 137);
        check("p1_done_cnt", done_cnt, 1);
        check("p1_busy_cyc", busy_cyc, 137);
        check("p1_latch_cyc", latch_cyc, 8);
        check("p1_low_pulses", low_pulses, 16);
        check("p1_low_cyc", low_cyc, 64);
        check("p1_min_low", min_len, 4);
        check("p1_max_low", max_len, 4);
        check("p1_hold", hold_bad, 0);
        check("p1_b1", b1_done, 16'hA5C3);
        check("p1_b2", b2_done, 16'h0001);

        pif.auto_poll_en = 1'b1;
        pat1 = 16'h1234; pat2 = 16'h8000;
        run_poll(1, 160, -1, -1);
        check("auto_done_cyc", done_cyc, 137);
        check("auto_b1", b1_done, 16'h1234);
        check("auto_b2", b2_done, 16'h8000);
        pif.auto_poll_en = 1'b0;
        run_poll(1, 40, -1, -1);
        check("auto_off_busy", busy_cyc, 0);

        pif.auto_poll_en = 1'b1;
        pat1 = 16'h00FF; pat2 = 16'hFF00;
        run_poll(0, 250, 50, 60);
        check("drop_done_cnt", done_cnt, 1);
        check("drop_done_cyc", done_cyc, 137);
        check("drop_b1", b1_done, 16'h00FF);
        check("drop_b2", b2_done, 16'hFF00);
        pif.auto_poll_en = 1'b0;
        pat1 = 16'h0F0F; pat2 = 16'hF0F0;
        run_poll(0, 160, -1, -1);
        check("after_drop_done_cyc", done_cyc, 137);
        check("after_drop_b1", b1_done, 16'h0F0F);

        pat1 = 16'h5555; pat2 = 16'hAAAA;
        run_poll(0, 69, -1, -1);
        check("mid_busy_before", pif.busy, 1'b1);
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("mid_latch", pif.pad_latch, 1'b0);
        check("mid_clk", pif.pad_clk, 1'b1);
        check("mid_busy", pif.busy, 1'b0);
        check("mid_b1", pif.pad1_buttons, 16'h0000);
        check("mid_b2", pif.pad2_buttons, 16'h0000);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (pif.done) bad++;
        end
        resetn = 1'b1;
        check("mid_no_done_in_rst", bad, 0);
        run_poll(2, 150, -1, -1);
        check("mid_no_done_after", done_cnt, 0);
        check("mid_idle_after", busy_cyc, 0);
        pat1 = 16'hC003; pat2 = 16'h3C00;
        run_poll(0, 160, -1, -1);
        check("fresh_done_cyc", done_cyc, 137);
        check("fresh_b1", b1_done, 16'hC003);
        check("fresh_b2", b2_done, 16'h3C00);

        pat1 = 16'hFFFF; pat2 = 16'hFFFF;
        run_poll(0, 160, -1, -1);
        check("atom_pre_b1", b1_done, 16'hFFFF);
        check("atom_pre_b2", b2_done, 16'hFFFF);
        pat1 = 16'h0000; pat2 = 16'h0000;
        run_poll(0, 160, -1, -1);
        check("atom_hold", hold_bad, 0);
        check("atom_done_cyc", done_cyc, 137);
        check("atom_b1", b1_done, 16'h0000);
        check("atom_b2", b2_done, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pad_reader.md
Name: pad_reader

Overview:
Serial gamepad reader that replaces the button-mocked pad path. It drives SNES-style latch and clock lines to two pads and shifts in 16 bits from each pad. It presents debounced-by-frame, active-high button words to the bus-side pad register. Polls start on a CPU request or automatically once per frame, using the VDP frame-end pulse.

Parameters:
CLK_DIV, 64, clk cycles per pad_clk half-period; also sets latch width (2*CLK_DIV); legal range 4..1024
PAD_BITS, 16, bits shifted per pad per poll

Ports:
clk  input  1  system clock (vdp_clk domain)
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle poll request from bus write
frame_tick  input  1  one-cycle pulse at end of active frame
auto_poll_en  input  1  when 1, frame_tick starts a poll
busy  output  1  poll in progress
done  output  1  one-cycle pulse; button words updated this cycle
pad_latch  output  1  pad latch line, active high
pad_clk  output  1  pad clock line, idles high
pad_data  input  2  serial data from pad 1 [0] and pad 2 [1], active low, asynchronous
pad1_buttons  output  PAD_BITS  pad 1 state, 1 = pressed, bit 0 = first bit shifted
pad2_buttons  output  PAD_BITS  pad 2 state, same format

Behaviour:
- Reset (async, resetn=0): state IDLE, pad_latch=0, pad_clk=1, busy=0, done=0, pad1/pad2_buttons=0, counters=0, sync flops=2'b11.
- pad_data passes through a 2-flop synchronizer before use. Each sample therefore reflects pad_data from 2 cycles earlier.
- Trigger: trig = start | (frame_tick & auto_poll_en), evaluated only in IDLE. A trigger while busy is dropped, not queued. start and frame_tick in the same cycle start a single poll.
- States:
  - IDLE: latch=0, clk=1. On trig, go to LATCH next cycle; busy rises in that cycle.
  - LATCH: latch=1, clk=1 for exactly 2*CLK_DIV cycles, then HIGH with bit index 0.
  - HIGH: latch=0, clk=1 for CLK_DIV cycles. On the last HIGH cycle, capture the inverted synchronized data into shift[bit] for both pads. Then go to LOW.
  - LOW: clk=0 for CLK_DIV cycles. If bit==PAD_BITS-1, go to DONE; otherwise bit++ and go to HIGH (the rising edge shifts the pad).
  - DONE: one cycle. done=1; pad1/pad2_buttons <= shift registers (atomic, both pads same edge); busy=1; go to IDLE next cycle.
- Total busy window = 2*CLK_DIV + 2*PAD_BITS*CLK_DIV + 1 cycles (CLK_DIV=4 → 137).
- Button outputs hold their previous value throughout a poll; partial results are never visible.
- A disconnected pad (data pulled high) reads all zeros.
- Counters: phase counter width clog2(2*CLK_DIV); bit counter width clog2(PAD_BITS). There is no wrap beyond PAD_BITS-1.
- Reset mid-poll returns to IDLE immediately and clears the button words. No done pulse is issued.
- Outputs pad_latch and pad_clk are registered (glitch-free).

Decomposition:
- Shared package holds the state encoding (IDLE, LATCH, HIGH, LOW, DONE), the PAD_BITS default, and the button bit index constants (B, Y, SELECT, START, UP, DOWN, LEFT, RIGHT, A, X, L, R).
- Sub-module pad_input_sync: a 2-bit, 2-flop synchronizer with async active-low reset to 1.

Test Plan (CLK_DIV=4):
- Reset values: hold resetn=0, then release → latch=0, clk=1, busy=0, buttons=0; no done for 200 cycles with no trigger.
- Single poll, pad 1 pattern 16'hA5C3 and pad 2 pattern 16'h0001 (pressed bits, so the bench drives active-low data per bit during each HIGH phase). Pulse start → latch high for exactly 8 cycles, 16 clk low pulses of 4 cycles each. done occurs 137 cycles after start's edge; pad1_buttons=16'hA5C3, pad2_buttons=16'h0001.
- Auto poll: auto_poll_en=1 with a frame_tick pulse → poll runs. With auto_poll_en=0, frame_tick is ignored (busy stays 0).
- Drop while busy: start at cycle 0 and again at cycle 50, frame_tick at cycle 60 → exactly one done; the next start after done begins a new poll.
- Atomicity: buttons start at 16'hFFFF and the next poll reads 16'h0000 → outputs stay 16'hFFFF until the done cycle, then both pads change on the same edge.
- Reset mid-poll: assert resetn=0 at cycle 70 of a poll → latch=0, clk=1, busy=0, buttons=0 asynchronously; no done pulse; a fresh start after release completes normally.
